// File: rtl/button_input_conditioner.sv
// Button input conditioner: per-button synchroniser, debouncer and press/release
// pulse generator, plus sticky press flags that survive until the next frame tick.
// Output bus input_data packs {press_pulse, release_pulse}.
module button_input_conditioner #(
   parameter int NUM_BUTTONS     = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_BUTTONS-1:0]   btn_raw,
   input  logic                     frame_tick,
   output logic [2*NUM_BUTTONS-1:0] input_data,
   output logic [NUM_BUTTONS-1:0]   btn_held,
   output logic [NUM_BUTTONS-1:0]   press_pending,
   output logic                     any_activity
);

   // Counter only has to reach DEBOUNCE_CYCLES-1; at least one bit wide.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_BUTTONS-1:0]   sync_q [SYNC_STAGES];
   logic [NUM_BUTTONS-1:0]   sync_d [SYNC_STAGES];
   logic [CNT_W-1:0]         cnt_q  [NUM_BUTTONS];
   logic [CNT_W-1:0]         cnt_d  [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0]   stable_q;
   logic [NUM_BUTTONS-1:0]   stable_d;
   logic [NUM_BUTTONS-1:0]   press_d;
   logic [NUM_BUTTONS-1:0]   release_d;
   logic [NUM_BUTTONS-1:0]   sync_last;
   logic [2*NUM_BUTTONS-1:0] input_data_q;
   logic [2*NUM_BUTTONS-1:0] input_data_d;
   logic [NUM_BUTTONS-1:0]   pending_q;
   logic [NUM_BUTTONS-1:0]   pending_d;
   logic                     any_q;
   logic                     any_d;

   assign sync_last = sync_q[SYNC_STAGES-1];

   // Synchroniser chain: raw level enters stage 0 and shifts toward the last stage.
   always_comb begin
      sync_d[0] = btn_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Debounce: a differing synchronised level must persist DEBOUNCE_CYCLES edges
   // before it is accepted; acceptance produces the matching one-cycle pulse.
   always_comb begin
      stable_d  = stable_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_last[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i]  = sync_last[i];
            cnt_d[i]     = '0;
            press_d[i]   = sync_last[i];
            release_d[i] = ~sync_last[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Output bus, sticky press flags (a press on the tick edge wins) and activity flag.
   always_comb begin
      input_data_d = {press_d, release_d};
      pending_d    = press_d | (pending_q & ~{NUM_BUTTONS{frame_tick}});
      any_d        = |input_data_d;
   end

   // State registers with synchronous active-low reset; reset drops any count in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_q[i] <= '0;
         end
         stable_q     <= '0;
         input_data_q <= '0;
         pending_q    <= '0;
         any_q        <= 1'b0;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stable_q     <= stable_d;
         input_data_q <= input_data_d;
         pending_q    <= pending_d;
         any_q        <= any_d;
      end
   end

   assign input_data    = input_data_q;
   assign btn_held      = stable_q;
   assign press_pending = pending_q;
   assign any_activity  = any_q;

endmodule

// File: tb/tb_button_input_conditioner.sv
// Testbench for button_input_conditioner: a reference model feeds a scoreboard
// queue every cycle, a vector table covers reset/first press, and directed
// sequences cover latency, bounce, sticky flags and reset mid-debounce.
module tb_button_input_conditioner;

   localparam int NB = 5;
   localparam int SS = 2;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic          frame_tick;
   logic [2*NB-1:0] input_data;
   logic [NB-1:0] btn_held;
   logic [NB-1:0] press_pending;
   logic          any_activity;

   button_input_conditioner #(
      .NUM_BUTTONS     (NB),
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_raw       (btn_raw),
      .frame_tick    (frame_tick),
      .input_data    (input_data),
      .btn_held      (btn_held),
      .press_pending (press_pending),
      .any_activity  (any_activity)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] data;
      logic [4:0] held;
      logic [4:0] pend;
      logic       any;
   } exp_t;

   typedef struct {
      logic       r;
      logic [4:0] raw;
      logic       tick;
      logic [9:0] data;
      logic [4:0] held;
      logic [4:0] pend;
      logic       any;
   } vec_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: synchroniser pipe, window of recent synced samples.
   logic [4:0] m_pipe [SS];
   logic [4:0] m_win  [DB];
   logic [4:0] m_stable;
   logic [4:0] m_pend;

   logic [9:0] obs_data;
   logic [4:0] obs_held;
   logic [4:0] obs_pend;
   logic       obs_any;

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // A level is accepted once the last DB synced samples all differ from it.
   task automatic model_edge(input logic r, input logic [4:0] raw, input logic tick,
                             output exp_t e);
      logic [4:0] s, acc, pr, rl;
      if (!r) begin
         for (int k = 0; k < SS; k++) m_pipe[k] = 5'd0;
         for (int k = 0; k < DB; k++) m_win[k] = 5'd0;
         m_stable = 5'd0;
         m_pend   = 5'd0;
         e.data = 10'd0; e.held = 5'd0; e.pend = 5'd0; e.any = 1'b0;
      end else begin
         s = m_pipe[SS-1];
         for (int k = DB-1; k > 0; k--) m_win[k] = m_win[k-1];
         m_win[0] = s;
         acc = 5'h1F;
         for (int k = 0; k < DB; k++) acc = acc & (m_win[k] ^ m_stable);
         pr = acc & s;
         rl = acc & ~s;
         m_stable = m_stable ^ acc;
         m_pend   = pr | (m_pend & ~{5{tick}});
         for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = raw;
         e.data = {pr, rl}; e.held = m_stable; e.pend = m_pend; e.any = |{pr, rl};
      end
   endtask

   // Drive one cycle, queue the model's expectation, compare after the edge.
   task automatic step(input logic r, input logic [4:0] raw, input logic tick);
      exp_t e, q;
      reset      = r;
      btn_raw    = raw;
      frame_tick = tick;
      model_edge(r, raw, tick, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      q = sb_q.pop_front();
      obs_data = input_data;
      obs_held = btn_held;
      obs_pend = press_pending;
      obs_any  = any_activity;
      chk("sb_input_data", obs_data, q.data);
      chk("sb_btn_held", {5'd0, obs_held}, {5'd0, q.held});
      chk("sb_press_pending", {5'd0, obs_pend}, {5'd0, q.pend});
      chk("sb_any_activity", {9'd0, obs_any}, {9'd0, q.any});
   endtask

   vec_t tbl [12];
   int   pat [7] = '{1, 1, 0, 1, 1, 1, 0};

   initial begin
      int pc, pe, rc, re, early;
      reset = 1'b0; btn_raw = 5'h1F; frame_tick = 1'b0;

      // Reset with all buttons held, release: first sampling edge is row 3, pulse at row 8.
      tbl[0]  = '{1'b0, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[1]  = '{1'b0, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[2]  = '{1'b0, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[3]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[4]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[5]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[6]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[7]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h00, 5'h00, 1'b0};
      tbl[8]  = '{1'b1, 5'h1F, 1'b0, 10'h3E0, 5'h1F, 5'h1F, 1'b1};
      tbl[9]  = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h1F, 5'h1F, 1'b0};
      tbl[10] = '{1'b1, 5'h1F, 1'b1, 10'h000, 5'h1F, 5'h00, 1'b0};
      tbl[11] = '{1'b1, 5'h1F, 1'b0, 10'h000, 5'h1F, 5'h00, 1'b0};

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].raw, tbl[i].tick);
         chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].data);
         chk($sformatf("tbl%0d_held", i), {5'd0, obs_held}, {5'd0, tbl[i].held});
         chk($sformatf("tbl%0d_pend", i), {5'd0, obs_pend}, {5'd0, tbl[i].pend});
         chk($sformatf("tbl%0d_any", i), {9'd0, obs_any}, {9'd0, tbl[i].any});
      end

      // Release everything and clear the sticky flags.
      for (int k = 0; k < 8; k++) step(1'b1, 5'h00, 1'b0);
      chk("all_released", {5'd0, obs_held}, 10'd0);
      step(1'b1, 5'h00, 1'b1);
      step(1'b1, 5'h00, 1'b0);

      // Clean press of bit 0 for 20 cycles, then release.
      pc = 0; pe = -1; rc = 0; re = -1;
      for (int k = 0; k < 35; k++) begin
         step(1'b1, (k < 20) ? 5'h01 : 5'h00, 1'b0);
         if (obs_data[5]) begin pc++; pe = k; end
         if (obs_data[0]) begin rc++; re = k; end
         if (k == 4)  chk("b0_held_before", {9'd0, obs_held[0]}, 10'd0);
         if (k == 12) chk("b0_held_mid", {9'd0, obs_held[0]}, 10'd1);
         if (k == 24) chk("b0_held_late", {9'd0, obs_held[0]}, 10'd1);
      end
      chk("b0_press_count", 10'(pc), 10'd1);
      chk("b0_press_edge", 10'(pe), 10'd5);
      chk("b0_release_count", 10'(rc), 10'd1);
      chk("b0_release_edge", 10'(re), 10'd25);
      chk("b0_held_after", {9'd0, obs_held[0]}, 10'd0);

      // Bounce on bit 4, then steady high from index 7.
      pc = 0; pe = -1; rc = 0; early = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b1, {((k < 7) ? pat[k][0] : 1'b1), 4'h0}, 1'b0);
         if (obs_data[9]) begin pc++; pe = k; end
         if (obs_data[4]) rc++;
         if ((k < 12) && (obs_data != 10'd0)) early++;
      end
      chk("b4_press_count", 10'(pc), 10'd1);
      chk("b4_press_edge", 10'(pe), 10'd12);
      chk("b4_release_count", 10'(rc), 10'd0);
      chk("b4_bounce_quiet", 10'(early), 10'd0);
      chk("b4_held", {9'd0, obs_held[4]}, 10'd1);
      step(1'b1, 5'h10, 1'b1);

      // Press bit 3, tick ten cycles after the press.
      pc = 0;
      for (int k = 0; k < 17; k++) begin
         step(1'b1, 5'h18, (k == 15));
         if (k == 4) chk("b3_pend_before", {9'd0, obs_pend[3]}, 10'd0);
         if ((k >= 5) && (k <= 14) && obs_pend[3]) pc++;
         if (k == 15) chk("b3_pend_cleared", {9'd0, obs_pend[3]}, 10'd0);
         if (k == 16) chk("b3_pend_stays_clear", {9'd0, obs_pend[3]}, 10'd0);
      end
      chk("b3_pend_held_cycles", 10'(pc), 10'd10);

      // Press pulse of bit 2 lands on the same edge as a frame tick.
      for (int k = 0; k < 13; k++) begin
         step(1'b1, 5'h1C, (k == 5) || (k == 10));
         if (k == 5) begin
            chk("b2_pulse_on_tick", {9'd0, obs_data[7]}, 10'd1);
            chk("b2_pend_set_wins", {9'd0, obs_pend[2]}, 10'd1);
         end
         if (k == 9)  chk("b2_pend_retained", {9'd0, obs_pend[2]}, 10'd1);
         if (k == 10) chk("b2_pend_next_tick", {9'd0, obs_pend[2]}, 10'd0);
      end

      // Reset in the middle of bit 1's debounce; the count must restart from zero.
      for (int k = 0; k < 4; k++) step(1'b1, 5'h1E, 1'b0);
      chk("b1_no_pulse_yet", obs_data, 10'd0);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 5'h1E, 1'b0);
         chk("rst_data", obs_data, 10'd0);
         chk("rst_held", {5'd0, obs_held}, 10'd0);
         chk("rst_pend", {5'd0, obs_pend}, 10'd0);
      end
      pc = 0; pe = -1;
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 5'h1E, 1'b0);
         if (obs_data != 10'd0) begin pc++; pe = k; end
         if (k == 5) chk("b1_repress_data", obs_data, 10'h3C0);
      end
      chk("b1_repress_count", 10'(pc), 10'd1);
      chk("b1_repress_edge", 10'(pe), 10'd5);
      chk("b1_held_after", {5'd0, obs_held}, 10'h01E);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
